// File: rtl/seg_display_scan.sv
// rtl/seg_display_scan.sv - 6-digit multiplexed 7-segment scanner with field blink and buzzer
//
// Ports:
//   clk     in   system clock (single domain)
//   reset   in   asynchronous active-low reset
//   hour    in   [7:0] packed BCD hour   ([7:4] tens, [3:0] ones)
//   minute  in   [7:0] packed BCD minute
//   second  in   [7:0] packed BCD second
//   mode    in   [1:0] field to blink: 0 none, 1 hour, 2 minute, 3 second
//   alert   in   alarm active
//   an      out  [5:0] digit enables, active-low (an[5] hour tens .. an[0] second ones)
//   seg     out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp      out  decimal point, active-low
//   buzz    out  buzzer drive, active-high

module seg_display_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 25,
    parameter int BUZZ_DIV     = 12500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hour,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    input  logic [1:0] mode,
    input  logic       alert,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       buzz
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int BW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

    localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);
    localparam logic [BW-1:0] BUZZ_MAX  = BW'(BUZZ_DIV - 1);

    localparam logic [2:0] IDX_LAST = 3'd5;
    localparam logic [5:0] AN_OFF   = 6'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [2:0]    idx_q, idx_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [23:0]   snap_q, snap_d;
    logic          blank_q, blank_d;
    logic          show_q, show_d;
    logic          tone_q, tone_d;
    logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          buzz_q, buzz_d;

    logic          tick;
    logic          wrap;
    logic [1:0]    next_field;
    logic [3:0]    nibble;
    logic [5:0]    an_sel;
    logic [6:0]    seg_pat;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b0111111;
        endcase
        return p;
    endfunction

    always_comb begin
        tick = (prescaler_q == PRE_MAX);
        wrap = tick && (idx_q == IDX_LAST);

        prescaler_d = tick ? '0 : prescaler_q + 1'b1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? 3'd0 : idx_q + 3'd1;
        end

        // Frame boundary: snapshot, frame count and blink toggle share one edge,
        // so the new blink phase already governs idx0 of the new frame.
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        snap_d        = snap_q;
        if (wrap) begin
            snap_d = {hour, minute, second};
            if (frame_cnt_q == FRAME_MAX) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        case (idx_d)
            3'd0, 3'd1: next_field = 2'd1;
            3'd2, 3'd3: next_field = 2'd2;
            default:    next_field = 2'd3;
        endcase

        // Blank decision is frozen at the tick so mode changes only affect the next slot.
        blank_d = blank_q;
        if (tick) begin
            blank_d = blink_phase_d && (mode != 2'd0) && (mode == next_field);
        end
        show_d = tick;

        case (idx_q)
            3'd0:    begin nibble = snap_q[23:20]; an_sel = 6'b011111; end
            3'd1:    begin nibble = snap_q[19:16]; an_sel = 6'b101111; end
            3'd2:    begin nibble = snap_q[15:12]; an_sel = 6'b110111; end
            3'd3:    begin nibble = snap_q[11:8];  an_sel = 6'b111011; end
            3'd4:    begin nibble = snap_q[7:4];   an_sel = 6'b111101; end
            default: begin nibble = snap_q[3:0];   an_sel = 6'b111110; end
        endcase
        seg_pat = decode(nibble);

        // Tick cycle is dead-time: enables off, segments hold until the new slot is shown.
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (tick) begin
            an_d = AN_OFF;
        end else if (show_q) begin
            an_d  = blank_q ? AN_OFF : an_sel;
            seg_d = seg_pat;
            dp_d  = blank_q ? 1'b1 : ~((idx_q == 3'd1) || (idx_q == 3'd3));
        end

        buzz_cnt_d = (buzz_cnt_q == BUZZ_MAX) ? '0 : buzz_cnt_q + 1'b1;
        tone_d     = (buzz_cnt_q == BUZZ_MAX) ? ~tone_q : tone_q;
        // Silent during the dark blink phase, giving a beep-pause rhythm.
        buzz_d     = alert & tone_q & ~blink_phase_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler_q   <= '0;
            idx_q         <= IDX_LAST;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_q        <= '0;
            blank_q       <= 1'b0;
            show_q        <= 1'b0;
            tone_q        <= 1'b0;
            buzz_cnt_q    <= '0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
            buzz_q        <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            idx_q         <= idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            snap_q        <= snap_d;
            blank_q       <= blank_d;
            show_q        <= show_d;
            tone_q        <= tone_d;
            buzz_cnt_q    <= buzz_cnt_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            buzz_q        <= buzz_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign buzz = buzz_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// tb/tb_seg_display_scan.sv - scoreboard bench for seg_display_scan

module tb_seg_display_scan;

    localparam int D  = 4;
    localparam int B  = 2;
    localparam int BZ = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] hour, minute, second;
    logic [1:0] mode;
    logic       alert;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp, buzz;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       buzz;
        bit         chk_seg;
        bit         chk_dp;
    } exp_t;

    exp_t       q[$];
    exp_t       m_e;
    exp_t       mon_e;
    logic [6:0] seg_tab[16];

    int          n = 0;
    int          m_k, m_r, m_idx, m_fld, m_nib;
    bit          m_blank;
    logic [23:0] snap = '0;
    logic [1:0]  slot_mode = '0;

    seg_display_scan #(
        .SCAN_DIV(D),
        .BLINK_FRAMES(B),
        .BUZZ_DIV(BZ)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hour(hour),
        .minute(minute),
        .second(second),
        .mode(mode),
        .alert(alert),
        .an(an),
        .seg(seg),
        .dp(dp),
        .buzz(buzz)
    );

    always #5 clk = ~clk;

    // Blink phase after posedge m: wraps seen so far = frames started; phase flips every B frames.
    function automatic int phase_after(input int m);
        int k;
        int f;
        k = m / D;
        f = (k == 0) ? 0 : (k - 1) / 6 + 1;
        return (f / B) % 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rnd_time(input int tens_max);
        logic [7:0] v;
        if ($urandom_range(0, 7) == 0) v = 8'($urandom);
        else v = {4'($urandom_range(0, tens_max)), 4'($urandom_range(0, 9))};
        return v;
    endfunction

    // Reference model: expected outputs after each posedge from the edge count since reset release.
    always @(posedge clk) begin
        if (!reset) begin
            n = 0;
        end else begin
            n++;
            m_k = n / D;
            m_r = n % D;
            if (m_k >= 1 && m_r == 0) begin
                if ((m_k - 1) % 6 == 0) snap = {hour, minute, second};
                slot_mode = mode;
            end
            m_e.buzz    = alert & (((n - 1) / BZ) % 2 == 1) & (phase_after(n - 1) == 0);
            m_e.chk_seg = 1'b0;
            m_e.chk_dp  = 1'b0;
            m_e.seg     = 7'h7F;
            m_e.dp      = 1'b1;
            m_e.an      = 6'h3F;
            if (m_k == 0) begin
                m_e.chk_seg = 1'b1;
                m_e.chk_dp  = 1'b1;
            end else if (m_r != 0) begin
                m_idx   = (m_k - 1) % 6;
                m_fld   = m_idx / 2 + 1;
                m_blank = (slot_mode != 0) && (int'(slot_mode) == m_fld) && (phase_after(m_k * D) == 1);
                m_e.chk_dp = 1'b1;
                if (!m_blank) begin
                    m_nib       = int'((snap >> (4 * (5 - m_idx))) & 24'hF);
                    m_e.an      = 6'h3F & ~(6'b100000 >> m_idx);
                    m_e.seg     = seg_tab[m_nib];
                    m_e.chk_seg = 1'b1;
                    m_e.dp      = (m_idx == 1 || m_idx == 3) ? 1'b0 : 1'b1;
                end
            end
            q.push_back(m_e);
        end
    end

    always @(negedge clk) begin
        if (reset && q.size() > 0) begin
            mon_e = q.pop_front();
            check("an", 32'(an), 32'(mon_e.an));
            check("buzz", 32'(buzz), 32'(mon_e.buzz));
            if (mon_e.chk_seg) check("seg", 32'(seg), 32'(mon_e.seg));
            if (mon_e.chk_dp) check("dp", 32'(dp), 32'(mon_e.dp));
        end
    end

    task automatic rand_cycles(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 24))
                0: hour   = rnd_time(2);
                1: minute = rnd_time(5);
                2: second = rnd_time(5);
                3: mode   = 2'($urandom_range(0, 3));
                4: alert  = ~alert;
                default: ;
            endcase
        end
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        hour   = 8'h12;
        minute = 8'h34;
        second = 8'h56;
        mode   = 2'd0;
        alert  = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("reset_an", 32'(an), 32'h3F);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp", 32'(dp), 32'h1);
        check("reset_buzz", 32'(buzz), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        repeat (6 * D * 2) @(negedge clk);

        second = 8'h59;
        repeat (6 * D) @(negedge clk);
        repeat (2 * D + 1) @(negedge clk);
        second = 8'h00;
        repeat (6 * D * 2) @(negedge clk);

        hour  = 8'h1C;
        mode  = 2'd2;
        alert = 1'b1;
        repeat (6 * D * 6) @(negedge clk);
        alert = 1'b0;
        repeat (10) @(negedge clk);

        rand_cycles(1500);

        @(posedge clk);
        #2;
        reset = 1'b0;
        q.delete();
        #1;
        check("async_an", 32'(an), 32'h3F);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_dp", 32'(dp), 32'h1);
        check("async_buzz", 32'(buzz), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        rand_cycles(300);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
